// File: rtl/rr_dispatch_ctrl_pkg.sv
// Shared definitions for the round-robin dispatcher: state encoding,
// channel count and the round-robin pick function.
package rr_dispatch_ctrl_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_NOSEL  = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    // First enabled channel after 'last', wrapping so 'last' itself is checked last.
    function automatic logic [SELW-1:0] rr_pick(input logic [NCH-1:0]  mask,
                                                input logic [SELW-1:0] last);
        logic [SELW-1:0] idx;
        logic [SELW-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = last + SELW'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_dispatch_ctrl_demux.sv
// 1-to-8 demultiplexer: routes x onto output bit sel, all other bits low.
module dispatch_demux1to8
    import rr_dispatch_ctrl_pkg::*;
(
    input  logic            x,
    input  logic [SELW-1:0] sel,
    output logic [NCH-1:0]  z
);

    always_comb begin
        z      = '0;
        z[sel] = x;
    end

endmodule

// File: rtl/rr_dispatch_ctrl.sv
// Round-robin dispatcher: buffers one word and hands it to the next enabled
// channel after the last one served, holding the target until it is taken.
module rr_dispatch_ctrl
    import rr_dispatch_ctrl_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic            clock,
    input  logic            reset_,
    input  logic [NCH-1:0]  en_mask,
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    output logic [W-1:0]    out_data,
    output logic [NCH-1:0]  out_valid,
    input  logic [NCH-1:0]  out_ready,
    output logic [SELW-1:0] sel,
    output logic [CW-1:0]   sent_cnt,
    output logic [1:0]      dbg_state
);

    // Handshakes: a word moves on an edge where valid and ready are both high;
    // in_ready and out_valid never depend on in_valid.
    state_e          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] last_q, last_d;
    logic [W-1:0]    data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            locked;
    logic            out_hs;
    logic            accept;

    assign locked   = (state_q == ST_LOCKED);
    assign out_hs   = locked & out_ready[sel_q];
    assign in_ready = reset_ & ((state_q == ST_EMPTY) | out_hs);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    data_d = in_data;
                    if (|en_mask) begin
                        state_d = ST_LOCKED;
                        sel_d   = rr_pick(en_mask, last_q);
                    end else begin
                        state_d = ST_NOSEL;
                    end
                end
            end
            ST_NOSEL: begin
                if (|en_mask) begin
                    state_d = ST_LOCKED;
                    sel_d   = rr_pick(en_mask, last_q);
                end
            end
            ST_LOCKED: begin
                if (out_hs) begin
                    last_d = sel_q;
                    cnt_d  = cnt_q + CW'(1);
                    if (accept) begin
                        // Pick for the new word starts after the channel just served.
                        data_d = in_data;
                        if (|en_mask) begin
                            state_d = ST_LOCKED;
                            sel_d   = rr_pick(en_mask, sel_q);
                        end else begin
                            state_d = ST_NOSEL;
                        end
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= ST_EMPTY;
            sel_q   <= '0;
            last_q  <= SELW'(NCH - 1);
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    dispatch_demux1to8 u_demux (
        .x   (locked),
        .sel (sel_q),
        .z   (out_valid)
    );

    assign out_data  = data_q;
    assign sel       = sel_q;
    assign sent_cnt  = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_dispatch_ctrl.sv
// Directed bench for rr_dispatch_ctrl: stimulus pushes expected {channel, word}
// into a queue, a negedge monitor pops and compares on every output handshake.
module tb_rr_dispatch_ctrl;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int EW = W + 3;

    logic          clock;
    logic          reset_;
    logic [7:0]    en_mask;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [2:0]    sel;
    logic [CW-1:0] sent_cnt;
    logic [1:0]    dbg_state;

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cycle    = 0;

    rr_dispatch_ctrl #(.W(W), .CW(CW)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .sent_cnt  (sent_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset_   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_ = 1'b1;
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [W-1:0] d, input int ch, input bit expect_out);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        if (expect_out) exp_q.push_back({3'(ch), d});
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            if (in_ready === 1'b1) done = 1'b1;
            @(posedge clock); #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [EW-1:0] e;
        logic [2:0]    ch;
        logic [7:0]    onehot;
        if (reset_ === 1'b1 && (out_valid & out_ready) != 8'h00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                e      = exp_q.pop_front();
                ch     = e[EW-1:W];
                onehot = 8'h01 << ch;
                check("out_sel", 32'(sel), 32'(ch));
                check("out_valid_onehot", 32'(out_valid), 32'(onehot));
                check("out_data", 32'(out_data), 32'(e[W-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        reset_    = 1'b0;
        en_mask   = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 8'hFF;

        // 1. reset with in_valid high
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'h00);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clock); #1 reset_ = 1'b1;
        send_word(8'h11, 0, 1'b1);
        @(posedge clock); #1;
        check("t1_sent_cnt", 32'(sent_cnt), 32'd1);

        // 2. full rotation, one word per cycle
        do_reset();
        t0 = cycle;
        for (int i = 0; i < 10; i++) send_word(W'(i), i % 8, 1'b1);
        check("t2_throughput_cycles", 32'(cycle - t0), 32'd10);
        repeat (2) @(posedge clock); #1;
        check("t2_sent_cnt", 32'(sent_cnt), 32'd10);

        // 3. sparse mask 1010_0100, last served = 1
        en_mask = 8'b1010_0100;
        send_word(8'h30, 2, 1'b1);
        send_word(8'h31, 5, 1'b1);
        send_word(8'h32, 7, 1'b1);
        send_word(8'h33, 2, 1'b1);
        repeat (2) @(posedge clock); #1;
        check("t3_sent_cnt", 32'(sent_cnt), 32'd14);

        // 4. backpressure on channel 3
        en_mask   = 8'h08;
        out_ready = 8'hF7;
        send_word(8'h44, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t4_out_valid_hold", 32'(out_valid), 32'h08);
            check("t4_out_data_hold", 32'(out_data), 32'h44);
            check("t4_in_ready_low", 32'(in_ready), 32'd0);
            check("t4_sent_cnt_hold", 32'(sent_cnt), 32'd14);
        end
        @(posedge clock); #1 out_ready = 8'hFF;
        @(negedge clock);
        check("t4_in_ready_on_hs", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        check("t4_sent_cnt_once", 32'(sent_cnt), 32'd15);
        check("t4_out_valid_after", 32'(out_valid), 32'h00);

        // 5. empty mask parks the word in NOSEL
        en_mask = 8'h00;
        send_word(8'hA5, 6, 1'b1);
        repeat (2) begin
            @(negedge clock);
            check("t5_state_nosel", 32'(dbg_state), 32'd1);
            check("t5_out_valid_zero", 32'(out_valid), 32'h00);
            check("t5_in_ready_zero", 32'(in_ready), 32'd0);
        end
        @(posedge clock); #1 en_mask = 8'h40;
        @(negedge clock);
        check("t5_valid_registered", 32'(out_valid), 32'h00);
        repeat (2) @(posedge clock); #1;
        check("t5_sent_cnt", 32'(sent_cnt), 32'd16);

        // 6. reset while locked on channel 5
        en_mask   = 8'h20;
        out_ready = 8'h00;
        send_word(8'h66, 5, 1'b0);
        @(negedge clock);
        check("t6_locked_sel", 32'(sel), 32'd5);
        check("t6_locked_valid", 32'(out_valid), 32'h20);
        @(posedge clock); #1 reset_ = 1'b0;
        @(negedge clock);
        check("t6_in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("t6_out_valid_reset", 32'(out_valid), 32'h00);
        check("t6_state_reset", 32'(dbg_state), 32'd0);
        check("t6_sent_cnt_reset", 32'(sent_cnt), 32'd0);
        reset_    = 1'b1;
        en_mask   = 8'hFF;
        out_ready = 8'hFF;
        send_word(8'h77, 0, 1'b1);
        repeat (2) @(posedge clock); #1;
        check("t6_sent_cnt_after", 32'(sent_cnt), 32'd1);

        // ---------------- report ----------------
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
